// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: drives one Montgomery multiplier to compute
// base^exp mod m by left-to-right square-and-multiply. Operands arrive already
// in the Montgomery domain. A final multiply-by-1 converts the result back to
// the normal domain.
module mont_exp_ctrl #(
  parameter int K    = 192,
  parameter int EW   = 192,
  parameter int LOGE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [K-1:0]  base_m,
  input  logic [K-1:0]  one_m,
  input  logic [EW-1:0] exp,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [K-1:0]  result,
  output logic [K-1:0]  mm_x,
  output logic [K-1:0]  mm_y,
  output logic          mm_start,
  input  logic          mm_done,
  input  logic [K-1:0]  mm_z
);

  localparam logic [K-1:0]    ONE_K     = {{(K-1){1'b0}}, 1'b1};
  localparam logic [LOGE-1:0] IDX_TOP   = LOGE'(EW - 1);
  localparam logic [LOGE-1:0] IDX_ZERO  = {LOGE{1'b0}};
  localparam logic [LOGE-1:0] IDX_ONE   = {{(LOGE-1){1'b0}}, 1'b1};

  // REQ/WAIT are the two halves of every multiplier transaction; op_q says
  // which of square, multiply or domain conversion the transaction belongs to.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_STEP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_SQ   = 2'd0,
    OP_MUL  = 2'd1,
    OP_CONV = 2'd2
  } op_t;

  state_t          state_q;
  op_t             op_q;
  logic [K-1:0]    base_q;
  logic [K-1:0]    one_q;
  logic [EW-1:0]   exp_q;
  logic [LOGE-1:0] idx_q;
  logic [K-1:0]    acc_q;
  logic            busy_q;
  logic            done_q;
  logic [K-1:0]    result_q;
  logic [K-1:0]    mm_x_q;
  logic [K-1:0]    mm_y_q;
  logic            mm_start_q;

  logic            exp_bit;
  logic            idx_last;

  assign exp_bit  = exp_q[idx_q];
  assign idx_last = (idx_q == IDX_ZERO);

  // ready also waits on mm_done so a multiplier run left over from an aborted
  // operation is never overlapped by a new request.
  assign ready    = (state_q == S_IDLE) && mm_done;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_x     = mm_x_q;
  assign mm_y     = mm_y_q;
  assign mm_start = mm_start_q;

  // Exponent scan / transaction sequencer with registered outputs.
  // Operands are loaded on the same edge that enters S_REQ and are left
  // untouched until the next transaction is issued, so they stay stable
  // through the whole REQ/WAIT handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_SQ;
      base_q     <= {K{1'b0}};
      one_q      <= {K{1'b0}};
      exp_q      <= {EW{1'b0}};
      idx_q      <= IDX_ZERO;
      acc_q      <= {K{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= {K{1'b0}};
      mm_x_q     <= {K{1'b0}};
      mm_y_q     <= {K{1'b0}};
      mm_start_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && mm_done) begin
            base_q  <= base_m;
            one_q   <= one_m;
            exp_q   <= exp;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end

        // Skip leading zeros; the top set bit seeds acc with the base.
        S_SCAN: begin
          if (exp_bit) begin
            acc_q      <= base_q;
            mm_x_q     <= base_q;
            mm_start_q <= 1'b1;
            state_q    <= S_REQ;
            if (idx_last) begin
              op_q   <= OP_CONV;
              mm_y_q <= ONE_K;
            end else begin
              op_q   <= OP_SQ;
              mm_y_q <= base_q;
              idx_q  <= idx_q - IDX_ONE;
            end
          end else if (idx_last) begin
            // exp == 0: the answer is 1, reached by converting R mod m.
            acc_q      <= one_q;
            op_q       <= OP_CONV;
            mm_x_q     <= one_q;
            mm_y_q     <= ONE_K;
            mm_start_q <= 1'b1;
            state_q    <= S_REQ;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end

        // Hold start until the multiplier shows it has taken the request.
        S_REQ: begin
          if (!mm_done) begin
            mm_start_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mm_done) begin
            acc_q <= mm_z;
            case (op_q)
              OP_SQ: begin
                if (exp_bit) begin
                  op_q       <= OP_MUL;
                  mm_x_q     <= mm_z;
                  mm_y_q     <= base_q;
                  mm_start_q <= 1'b1;
                  state_q    <= S_REQ;
                end else begin
                  state_q <= S_STEP;
                end
              end
              OP_MUL: begin
                state_q <= S_STEP;
              end
              OP_CONV: begin
                result_q <= mm_z;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
              default: begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            endcase
          end
        end

        S_STEP: begin
          mm_x_q     <= acc_q;
          mm_start_q <= 1'b1;
          state_q    <= S_REQ;
          if (idx_last) begin
            op_q   <= OP_CONV;
            mm_y_q <= ONE_K;
          end else begin
            op_q   <= OP_SQ;
            mm_y_q <= acc_q;
            idx_q  <= idx_q - IDX_ONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q     <= 1'b0;
          mm_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl: a behavioural Montgomery multiplier
// (R = 2^192, P-192 modulus) answers the controller, and a golden normal-domain
// modexp feeds a scoreboard of expected results.
module tb_mont_exp_ctrl;

  localparam int K    = 192;
  localparam int EW   = 192;
  localparam int LOGE = 8;
  localparam logic [K-1:0] P192 =
    192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [K-1:0]  base_m = '0;
  logic [K-1:0]  one_m = '0;
  logic [EW-1:0] exp = '0;
  logic          ready, busy, done;
  logic [K-1:0]  result, mm_x, mm_y;
  logic          mm_start;
  logic          mm_done;
  logic [K-1:0]  mm_z = '0;

  int checks = 0;
  int failures = 0;
  logic [K-1:0] sb_q[$];

  mont_exp_ctrl #(.K(K), .EW(EW), .LOGE(LOGE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_m(base_m), .one_m(one_m),
    .exp(exp), .ready(ready), .busy(busy), .done(done), .result(result),
    .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start), .mm_done(mm_done),
    .mm_z(mm_z)
  );

  always #5 clk = ~clk;

  // ---------------- golden arithmetic ----------------
  function automatic logic [K-1:0] mont(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K+1:0] a;
    a = '0;
    for (int i = 0; i < K; i++) begin
      if (x[i]) a = a + {2'b00, y};
      if (a[0]) a = a + {2'b00, P192};
      a = a >> 1;
    end
    if (a >= {2'b00, P192}) a = a - {2'b00, P192};
    return a[K-1:0];
  endfunction

  function automatic logic [K-1:0] modmul(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [2*K-1:0] p;
    p = {{K{1'b0}}, a} * {{K{1'b0}}, b};
    p = p % {{K{1'b0}}, P192};
    return p[K-1:0];
  endfunction

  function automatic logic [K-1:0] to_mont(input logic [K-1:0] a);
    logic [2*K-1:0] p;
    p = {a, {K{1'b0}}} % {{K{1'b0}}, P192};
    return p[K-1:0];
  endfunction

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [EW-1:0] e);
    logic [K-1:0] r;
    r = {{(K-1){1'b0}}, 1'b1};
    for (int i = EW - 1; i >= 0; i--) begin
      r = modmul(r, r);
      if (e[i]) r = modmul(r, b);
    end
    return r;
  endfunction

  // ---------------- behavioural multiplier ----------------
  int   ack_delay = 0;
  int   lat = 5;
  bit   force_busy = 1'b0;
  logic mm_done_q = 1'b1;
  logic armed = 1'b1;
  int   ack_cnt = 0;
  int   lat_cnt = 0;
  int   txn_cnt = 0;
  int   viol_cnt = 0;
  int   done_cnt = 0;
  logic [K-1:0] cap_x = '0;
  logic [K-1:0] cap_y = '0;

  assign mm_done = mm_done_q & ~force_busy;

  // Multiplier: optional accept delay, fixed latency, needs start low to re-arm.
  always @(posedge clk) begin
    if (!mm_done_q) begin
      if (busy && rst_n && (mm_x !== cap_x || mm_y !== cap_y)) viol_cnt++;
      if (!mm_start) armed <= 1'b1;
      if (lat_cnt >= lat - 1) begin
        mm_done_q <= 1'b1;
        mm_z      <= mont(cap_x, cap_y);
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else if (mm_start && armed && !force_busy) begin
      if (ack_cnt == 0) begin
        cap_x <= mm_x;
        cap_y <= mm_y;
      end else if (mm_x !== cap_x || mm_y !== cap_y) begin
        viol_cnt++;
      end
      if (ack_cnt >= ack_delay) begin
        mm_done_q <= 1'b0;
        armed     <= 1'b0;
        lat_cnt   <= 0;
        ack_cnt   <= 0;
        txn_cnt++;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      if (ack_cnt != 0 && busy) viol_cnt++;
      ack_cnt <= 0;
      if (!mm_start) armed <= 1'b1;
    end
  end

  // Count every cycle the done pulse is high.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic launch(input logic [K-1:0] b, input logic [K-1:0] o,
                        input logic [EW-1:0] e, output bit no_ready);
    no_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        no_ready = 1'b0;
        break;
      end
    end
    base_m = b;
    one_m  = o;
    exp    = e;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output bit to, output logic [K-1:0] r);
    to = 1'b1;
    r  = '0;
    if (done === 1'b1) begin
      to = 1'b0;
      r  = result;
    end else begin
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          to = 1'b0;
          r  = result;
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mm_start} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/mm_start=%b want 000", {busy, done, mm_start});
    end
    checks++;
    if (result !== '0 || mm_x !== '0 || mm_y !== '0) begin
      failures++;
      $display("FAIL reset_data: got result=%h mm_x=%h mm_y=%h want 0", result, mm_x, mm_y);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exp_zero();
    bit nr, to;
    logic [K-1:0] r, want;
    int t0, d0;
    logic [K-1:0] rm;
    rm = to_mont({{(K-1){1'b0}}, 1'b1});
    t0 = txn_cnt;
    d0 = done_cnt;
    sb_q.push_back(modexp({{(K-1){1'b0}}, 1'b1}, '0));
    launch(rm, rm, '0, nr);
    wait_done(to, r);
    want = sb_q.pop_front();
    checks++;
    if (to || nr || r !== want) begin
      failures++;
      $display("FAIL exp0_result: got %h (timeout=%0d) want %h", r, to, want);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (txn_cnt - t0 != 1) begin
      failures++;
      $display("FAIL exp0_txns: got %0d want 1", txn_cnt - t0);
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exp0_done_busy: got done_cycles=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic run_case(input string name, input logic [K-1:0] b,
                          input logic [EW-1:0] e, input int want_txn);
    bit nr, to;
    logic [K-1:0] r, want;
    int t0, v0;
    t0 = txn_cnt;
    v0 = viol_cnt;
    sb_q.push_back(modexp(b, e));
    launch(to_mont(b), to_mont({{(K-1){1'b0}}, 1'b1}), e, nr);
    wait_done(to, r);
    want = sb_q.pop_front();
    checks++;
    if (to || nr || r !== want) begin
      failures++;
      $display("FAIL %s_result: got %h (timeout=%0d) want %h", name, r, to, want);
    end
    @(negedge clk);
    checks++;
    if (txn_cnt - t0 != want_txn) begin
      failures++;
      $display("FAIL %s_txns: got %0d want %0d", name, txn_cnt - t0, want_txn);
    end
    checks++;
    if (viol_cnt != v0) begin
      failures++;
      $display("FAIL %s_handshake: got %0d violations want 0", name, viol_cnt - v0);
    end
  endtask

  task automatic test_f4();
    run_case("f4", 192'd2, 192'h10001, 18);
  endtask

  task automatic test_small_exps();
    run_case("exp1", 192'h1234, 192'd1, 1);
    run_case("exp3", 192'h1234, 192'd3, 3);
  endtask

  task automatic test_handshake();
    ack_delay = 4;
    run_case("slow_ack", 192'h1234, 192'd3, 3);
    ack_delay = 0;
  endtask

  task automatic test_ignored_start();
    bit nr, to;
    logic [K-1:0] r, want;
    int t0, d0;
    t0 = txn_cnt;
    sb_q.push_back(modexp(192'h1234, 192'd5));
    launch(to_mont(192'h1234), to_mont(192'd1), 192'd5, nr);
    repeat (4) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready: got %b want 0", ready);
    end
    base_m = to_mont(192'h5555);
    exp    = 192'd0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(to, r);
    want = sb_q.pop_front();
    checks++;
    if (to || nr || r !== want) begin
      failures++;
      $display("FAIL busy_start_result: got %h (timeout=%0d) want %h", r, to, want);
    end
    @(negedge clk);
    checks++;
    if (txn_cnt - t0 != 4) begin
      failures++;
      $display("FAIL busy_start_txns: got %0d want 4", txn_cnt - t0);
    end
    // Idle but multiplier not done: start must be ignored.
    force_busy = 1'b1;
    t0 = txn_cnt;
    d0 = done_cnt;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mmbusy_ready: got %b want 0", ready);
    end
    exp   = 192'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != d0 || result !== want || txn_cnt != t0) begin
      failures++;
      $display("FAIL mmbusy_ignored: got busy=%b done_cycles=%0d result=%h want busy=0 done_cycles=0 result=%h",
               busy, done_cnt - d0, result, want);
    end
    force_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit nr, to, hit;
    logic [K-1:0] r, want;
    int t0;
    t0 = txn_cnt;
    sb_q.push_back(modexp(192'd2, 192'h10001));
    launch(to_mont(192'd2), to_mont(192'd1), 192'h10001, nr);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txn_cnt - t0 == 3 && mm_done === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!hit || busy !== 1'b1 || mm_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_reach: got hit=%0d busy=%b mm_done=%b want 1 1 0", hit, busy, mm_done);
    end
    void'(sb_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mm_start, ready} !== 4'b0000 || result !== '0 || mm_x !== '0 || mm_y !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy/done/mm_start/ready=%b result=%h mm_x=%h want 0000 0 0",
               {busy, done, mm_start, ready}, result, mm_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mm_done === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: got mm_done_seen=%0d ready=%b want 1 1", hit, ready);
    end
    t0 = txn_cnt;
    sb_q.push_back(modexp(192'h1234, 192'd5));
    launch(to_mont(192'h1234), to_mont(192'd1), 192'd5, nr);
    wait_done(to, r);
    want = sb_q.pop_front();
    checks++;
    if (to || nr || r !== want) begin
      failures++;
      $display("FAIL midrst_restart: got %h (timeout=%0d) want %h", r, to, want);
    end
    @(negedge clk);
    checks++;
    if (txn_cnt - t0 != 4) begin
      failures++;
      $display("FAIL midrst_txns: got %0d want 4", txn_cnt - t0);
    end
  endtask

  initial begin
    test_reset();
    test_exp_zero();
    test_f4();
    test_small_exps();
    test_handshake();
    test_ignored_start();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
